// File: rtl/redundant_l3_normalizer.sv
// rtl/redundant_l3_normalizer.sv - resolves a redundant L3 polynomial into a plain binary integer
// One limb per cycle: ripple the 1-bit running carry plus the previous limb's carry field upward.
module redundant_l3_normalizer #(
    parameter int ADD_DIV = 4,
    parameter int LIMB_W  = 68,
    parameter int CARRY_W = 20,
    parameter int OUT_W   = LIMB_W * ADD_DIV + CARRY_W + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ADD_DIV*(CARRY_W+LIMB_W)-1:0] in_poly,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_W-1:0]                    out_uint
);

    localparam int LANE_W = CARRY_W + LIMB_W;
    localparam int POLY_W = ADD_DIV * LANE_W;
    localparam int KW     = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;
    localparam int TOP_W  = OUT_W - LIMB_W * ADD_DIV;
    localparam logic [KW-1:0] K_LAST = KW'(ADD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROP,
        S_FIN,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [POLY_W-1:0]   poly_q, poly_d;
    logic [KW-1:0]       k_q, k_d;
    logic                c_q, c_d;
    logic [OUT_W-1:0]    res_q, res_d;

    logic [LIMB_W-1:0]   val_k;
    logic [CARRY_W-1:0]  carry_prev;
    logic [CARRY_W-1:0]  carry_last;
    logic [LIMB_W:0]     s;
    logic [TOP_W-1:0]    top_sum;

    // Limb k's value field and limb k-1's carry field, both picked from the private copy.
    always_comb begin
        val_k      = '0;
        carry_prev = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            if (k_q == KW'(i)) begin
                val_k = poly_q[i*LANE_W +: LIMB_W];
            end
        end
        for (int i = 1; i < ADD_DIV; i++) begin
            if (k_q == KW'(i)) begin
                carry_prev = poly_q[(i-1)*LANE_W + LIMB_W +: CARRY_W];
            end
        end
        carry_last = poly_q[(ADD_DIV-1)*LANE_W + LIMB_W +: CARRY_W];
        s          = {1'b0, val_k} + (LIMB_W+1)'(carry_prev) + (LIMB_W+1)'(c_q);
        top_sum    = TOP_W'(carry_last) + TOP_W'(c_q);
    end

    always_comb begin
        state_d = state_q;
        poly_d  = poly_q;
        k_d     = k_q;
        c_d     = c_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    poly_d  = in_poly;
                    k_d     = '0;
                    c_d     = 1'b0;
                    res_d   = '0;
                    state_d = S_PROP;
                end
            end
            S_PROP: begin
                for (int i = 0; i < ADD_DIV; i++) begin
                    if (k_q == KW'(i)) begin
                        res_d[i*LIMB_W +: LIMB_W] = s[LIMB_W-1:0];
                    end
                end
                c_d = s[LIMB_W];
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = S_FIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_FIN: begin
                res_d[OUT_W-1 -: TOP_W] = top_sum;
                c_d     = 1'b0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            poly_q  <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            k_q     <= k_d;
            c_q     <= c_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_uint  = res_q;

endmodule

// File: tb/tb_redundant_l3_normalizer.sv
// tb/tb_redundant_l3_normalizer.sv - scoreboard bench for redundant_l3_normalizer
module tb_redundant_l3_normalizer;

    localparam int ADD_DIV = 4;
    localparam int LIMB_W  = 68;
    localparam int CARRY_W = 20;
    localparam int OUT_W   = LIMB_W * ADD_DIV + CARRY_W + 1;
    localparam int LANE_W  = CARRY_W + LIMB_W;
    localparam int PW      = ADD_DIV * LANE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_poly;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_uint;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit rand_mode = 1'b0;
    logic [OUT_W-1:0] sb[$];

    redundant_l3_normalizer #(
        .ADD_DIV(ADD_DIV), .LIMB_W(LIMB_W), .CARRY_W(CARRY_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_poly(in_poly),
        .out_valid(out_valid), .out_ready(out_ready), .out_uint(out_uint)
    );

    always #5 clk = ~clk;

    // Value represented by the polynomial, straight from the definition.
    function automatic logic [OUT_W-1:0] model(input logic [PW-1:0] p);
        logic [OUT_W-1:0] v;
        logic [OUT_W-1:0] limb;
        v = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            limb = OUT_W'(p[i*LANE_W +: LIMB_W]) + (OUT_W'(p[i*LANE_W+LIMB_W +: CARRY_W]) << LIMB_W);
            v = v + (limb << (LIMB_W * i));
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] put(input logic [PW-1:0] p, input int i,
                                          input logic [LIMB_W-1:0] v, input logic [CARRY_W-1:0] c);
        p[i*LANE_W +: LANE_W] = {c, v};
        return p;
    endfunction

    function automatic logic [PW-1:0] rand_poly();
        logic [PW-1:0] p;
        logic [95:0]   r;
        logic [CARRY_W-1:0] c;
        p = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            r = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r = '1;
            c = CARRY_W'($urandom);
            if ($urandom_range(0, 7) == 0) c = '1;
            p = put(p, i, r[LIMB_W-1:0], c);
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [OUT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_result: got %h expected no result", out_uint);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_uint, e);
                end
            end
        end
    endtask

    // Offers p until accepted, then queues the expected value and scrambles in_poly.
    task automatic send(input logic [PW-1:0] p, input logic [OUT_W-1:0] exp, output int waited);
        in_poly  = p;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (in_ready === 1'b1 || waited > 200) break;
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (in_ready !== 1'b1) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_poly  = rand_poly();
            if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [OUT_W-1:0] one;
        logic [OUT_W-1:0] cmax;
        logic [OUT_W-1:0] e;
        logic [PW-1:0]    p;
        logic [PW-1:0]    pb;
        int               w;
        int               n;
        bit               seen;

        one       = 1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_poly   = '0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", OUT_W'(in_ready), OUT_W'(1));
        chk("reset_out_valid", OUT_W'(out_valid), OUT_W'(0));
        chk("reset_out_uint", out_uint, '0);
        rst = 1'b0;

        // All-zero poly, with latency measured in cycles after the accept edge.
        send('0, '0, w);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) break;
        end
        chk("latency", OUT_W'(n), OUT_W'(6));
        repeat (2) @(posedge clk);
        #1;

        p = put('0, 0, '1, 1);
        send(p, (one << 69) - one, w);

        p = '0;
        for (int i = 0; i < ADD_DIV; i++) p = put(p, i, '1, (i == 0) ? 1 : 0);
        send(p, (one << 272) + (one << 68) - one, w);

        p = '1;
        cmax = (one << 20) - one;
        e = ((one << 272) - one) + cmax * ((one << 68) + (one << 136) + (one << 204) + (one << 272));
        send(p, e, w);
        chk("model_max", model(p), e);

        // Backpressure: result must hold and no new poly may be taken.
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        p = rand_poly();
        send(p, model(p), w);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        pb = rand_poly();
        in_poly  = pb;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", OUT_W'(out_valid), OUT_W'(1));
            chk("bp_in_ready", OUT_W'(in_ready), OUT_W'(0));
            chk("bp_out_uint", out_uint, model(p));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(pb, model(pb), w);
        chk("bp_accept_next", OUT_W'(w), OUT_W'(2));

        // Abort mid-PROP at k=2, with an asynchronous reset between edges.
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        p = put('0, 0, 68'h123456789, 7);
        send(p, model(p), w);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", OUT_W'(in_ready), OUT_W'(1));
        chk("abort_out_valid", OUT_W'(out_valid), OUT_W'(0));
        chk("abort_out_uint", out_uint, '0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_valid", OUT_W'(seen), OUT_W'(0));
        @(posedge clk);
        #1;
        p = put(put('0, 0, 5, 0), 3, 0, 3);
        send(p, OUT_W'(5) + (OUT_W'(3) << 272), w);

        rand_mode = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            p = rand_poly();
            send(p, model(p), w);
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("drain", OUT_W'(sb.size()), OUT_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
